misc_pc_sequencer: RTL and testbench
====================================

MISC_PC_SEQUENCER -- requirements
Module: misc_pc_sequencer

Interface
REQ-001 SHALL have parameter PC_RESET, default 16'hFFFC, the PC value loaded on reset.
REQ-002 SHALL have port CLK, input, 1, the single clock, rising-edge active.
REQ-003 SHALL have port RST_N, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have port sig_INC, input, 1, increment PC by 1.
REQ-005 SHALL have port sig_LDL, input, 1, load PCL from IN_DB.
REQ-006 SHALL have port sig_LDH, input, 1, load PCH from IN_DB.
REQ-007 SHALL have port sig_BR, input, 1, take a relative branch by signed IN_DB.
REQ-008 SHALL have port IN_DB, input, 8, data bus byte (load value or branch offset).
REQ-009 SHALL have port OUT_PCL, output, 8, registered PC low byte.
REQ-010 SHALL have port OUT_PCH, output, 8, registered PC high byte.
REQ-011 SHALL have port BUSY, output, 1, high while a page-cross fixup cycle is pending.
REQ-012 SHALL have port PAGE_X, output, 1, one-cycle pulse when a branch crossed a page.

Function
REQ-013 All outputs SHALL be registered; command effect is visible on OUT_PC* one cycle after the sampling edge.
REQ-014 sig_INC SHALL add 1 to PCL; carry out of PCL SHALL increment PCH in the same cycle; FFFF wraps to 0000.
REQ-015 sig_LDL / sig_LDH SHALL replace the respective byte; both high SHALL load both bytes from IN_DB.
REQ-016 sig_BR SHALL add sign-extended IN_DB to PCL only; on carry/borrow out of PCL the FSM SHALL enter FIXUP.
REQ-017 FSM states: IDLE, FIXUP; IDLE->FIXUP on branch page cross; FIXUP->IDLE unconditionally after one cycle.
REQ-018 In FIXUP, PCH SHALL be incremented (forward cross) or decremented (backward cross), BUSY SHALL be 1, PAGE_X SHALL pulse 1.
REQ-019 In FIXUP, all commands SHALL be ignored; the requester holds them until BUSY=0.
REQ-020 Priority in IDLE SHALL be: sig_BR > sig_LDL/sig_LDH > sig_INC; lower-priority commands are dropped that cycle.
REQ-021 Branch with no page cross SHALL complete in one cycle, BUSY stays 0, PAGE_X stays 0.
REQ-022 No command asserted SHALL hold PC unchanged.

Reset
REQ-023 RST_N low SHALL immediately set {OUT_PCH,OUT_PCL}=PC_RESET, BUSY=0, PAGE_X=0, FSM=IDLE.
REQ-024 Reset asserted during FIXUP SHALL abort the fixup; no PCH adjustment occurs after release.
REQ-025 Deassertion SHALL be taken on the next rising CLK; first command accepted on that edge.

Configuration
REQ-026 Macro MISC_PC_BRANCH_PENALTY_EN defined: page-cross branches SHALL behave per REQ-016..REQ-019.
REQ-027 Macro undefined: sig_BR SHALL add the sign-extended offset to the full 16-bit PC in one cycle; FIXUP unused, BUSY constant 0, PAGE_X pulses in that same cycle on page cross.

Structure
REQ-028 Package misc_pc_pkg SHALL hold the FSM state typedef (IDLE, FIXUP), the default PC_RESET constant, and the branch-direction enum.
REQ-029 One sub-module misc_pc_inc8 (8-bit increment/decrement with carry-in enable and carry-out) SHALL be instantiated twice, for PCL and PCH.

Verification
REQ-030 Reset release, PC_RESET default -> PC=FFFC, BUSY=0; sig_INC x4 -> PC=0000 (wrap).
REQ-031 PC=12FF, sig_INC -> PC=1300 after one cycle, no BUSY.
REQ-032 PC=1234, sig_LDL IN_DB=78 then sig_LDH IN_DB=56 -> PC=1278 then 5678.
REQ-033 PENALTY_EN, PC=10F0, sig_BR IN_DB=20 -> cycle1 PC=1010 BUSY=1; cycle2 PC=1110 PAGE_X=1 BUSY=0; sig_INC held during BUSY applied only after.
REQ-034 PENALTY_EN, PC=1005, sig_BR IN_DB=F0 (-16) -> 10F5 then 0FF5; without macro -> 0FF5 in one cycle, BUSY=0.
REQ-035 PC=10F0, sig_BR IN_DB=20, RST_N low during FIXUP -> PC=FFFC, BUSY=0, no later PCH change.

Source files
------------

// File: rtl/misc_pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Page-cross branch penalty is selected by MISC_PC_BRANCH_PENALTY_EN in the top.
package misc_pc_pkg;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'hFFFC;

  typedef enum logic {
    IDLE  = 1'b0,
    FIXUP = 1'b1
  } state_t;

  typedef enum logic {
    BR_FWD = 1'b0,
    BR_BWD = 1'b1
  } br_dir_t;

  // A negative offset can only borrow out of PCL, a positive one can only carry
  function automatic br_dir_t br_dir_of(input logic [7:0] offset);
    br_dir_t dir;
    if (offset[7]) begin
      dir = BR_BWD;
    end else begin
      dir = BR_FWD;
    end
    return dir;
  endfunction

endpackage

// File: rtl/misc_pc_inc8.sv
// 8-bit increment/decrement cell with enable and carry/borrow out.
// Used once for PCL and once for PCH.
module misc_pc_inc8 (
  input  logic [7:0] value,
  input  logic       en,
  input  logic       dec,
  output logic [7:0] result,
  output logic       carry
);

  // Pass-through when disabled; carry flags wrap in either direction
  always_comb begin
    result = value;
    carry  = 1'b0;
    if (!en) begin
      result = value;
      carry  = 1'b0;
    end else if (dec) begin
      result = value - 8'd1;
      carry  = (value == 8'h00);
    end else begin
      result = value + 8'd1;
      carry  = (value == 8'hFF);
    end
  end

endmodule

// File: rtl/misc_pc_sequencer.sv
// 16-bit program counter with increment, byte loads and relative branches.
// Define MISC_PC_BRANCH_PENALTY_EN to fix up PCH in an extra cycle on page-crossing branches.
module misc_pc_sequencer
  import misc_pc_pkg::*;
#(
  parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       sig_INC,
  input  logic       sig_LDL,
  input  logic       sig_LDH,
  input  logic       sig_BR,
  input  logic [7:0] IN_DB,
  output logic [7:0] OUT_PCL,
  output logic [7:0] OUT_PCH,
  output logic       BUSY,
  output logic       PAGE_X
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] pcl_r;
  logic [7:0] pch_r;
  logic [7:0] pcl_nxt_s;
  logic [7:0] pch_nxt_s;
  logic       busy_r;
  logic       busy_nxt_s;
  logic       page_x_r;
  logic       page_x_nxt_s;

  logic [7:0] pcl_inc_s;
  logic       pcl_co_s;
  logic [7:0] pch_adj_s;
  logic       pch_co_unused_s;
  logic       pch_en_s;
  logic       pch_dec_s;
  logic       pch_load_s;

  logic [8:0] br_sum_s;
  logic       br_cross_s;
  br_dir_t    br_dir_s;

`ifdef MISC_PC_BRANCH_PENALTY_EN
  br_dir_t    dir_r;
  br_dir_t    dir_nxt_s;
`endif

  // Unsigned 9-bit sum: a positive offset crosses on carry, a negative one on no carry
  assign br_sum_s   = {1'b0, pcl_r} + {1'b0, IN_DB};
  assign br_dir_s   = br_dir_of(IN_DB);
  assign br_cross_s = (br_dir_s == BR_BWD) ? ~br_sum_s[8] : br_sum_s[8];

  misc_pc_inc8 u_pcl_inc (
    .value  (pcl_r),
    .en     (sig_INC),
    .dec    (1'b0),
    .result (pcl_inc_s),
    .carry  (pcl_co_s)
  );

  misc_pc_inc8 u_pch_inc (
    .value  (pch_r),
    .en     (pch_en_s),
    .dec    (pch_dec_s),
    .result (pch_adj_s),
    .carry  (pch_co_unused_s)
  );

  // Command arbitration, FSM next state and next values of the registered outputs
  always_comb begin
    state_nxt_s  = state_r;
    pcl_nxt_s    = pcl_r;
    pch_en_s     = 1'b0;
    pch_dec_s    = 1'b0;
    pch_load_s   = 1'b0;
    busy_nxt_s   = 1'b0;
    page_x_nxt_s = 1'b0;
`ifdef MISC_PC_BRANCH_PENALTY_EN
    dir_nxt_s    = dir_r;
`endif
    case (state_r)
      IDLE: begin
        if (sig_BR) begin
          pcl_nxt_s = br_sum_s[7:0];
`ifdef MISC_PC_BRANCH_PENALTY_EN
          if (br_cross_s) begin
            state_nxt_s = FIXUP;
            dir_nxt_s   = br_dir_s;
            busy_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
`else
          pch_en_s     = br_cross_s;
          pch_dec_s    = (br_dir_s == BR_BWD);
          page_x_nxt_s = br_cross_s;
`endif
        end else if (sig_LDL || sig_LDH) begin
          if (sig_LDL) begin
            pcl_nxt_s = IN_DB;
          end else begin
            pcl_nxt_s = pcl_r;
          end
          pch_load_s = sig_LDH;
        end else if (sig_INC) begin
          pcl_nxt_s = pcl_inc_s;
          pch_en_s  = pcl_co_s;
        end else begin
          pcl_nxt_s = pcl_r;
        end
      end
      FIXUP: begin
        // Commands are ignored here; the requester holds them while BUSY is high
        state_nxt_s  = IDLE;
`ifdef MISC_PC_BRANCH_PENALTY_EN
        pch_en_s     = 1'b1;
        pch_dec_s    = (dir_r == BR_BWD);
        page_x_nxt_s = 1'b1;
`endif
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign pch_nxt_s = pch_load_s ? IN_DB : pch_adj_s;

  // PC, FSM and status registers; reset aborts any pending fixup
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= IDLE;
      pcl_r    <= PC_RESET[7:0];
      pch_r    <= PC_RESET[15:8];
      busy_r   <= 1'b0;
      page_x_r <= 1'b0;
`ifdef MISC_PC_BRANCH_PENALTY_EN
      dir_r    <= BR_FWD;
`endif
    end else begin
      state_r  <= state_nxt_s;
      pcl_r    <= pcl_nxt_s;
      pch_r    <= pch_nxt_s;
      busy_r   <= busy_nxt_s;
      page_x_r <= page_x_nxt_s;
`ifdef MISC_PC_BRANCH_PENALTY_EN
      dir_r    <= dir_nxt_s;
`endif
    end
  end

  assign OUT_PCL = pcl_r;
  assign OUT_PCH = pch_r;
  assign BUSY    = busy_r;
  assign PAGE_X  = page_x_r;

endmodule

// File: tb/tb_misc_pc_sequencer.sv
// Scoreboard bench for misc_pc_sequencer; expectations follow MISC_PC_BRANCH_PENALTY_EN.
module tb_misc_pc_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       sig_INC = 1'b0;
  logic       sig_LDL = 1'b0;
  logic       sig_LDH = 1'b0;
  logic       sig_BR = 1'b0;
  logic [7:0] IN_DB = 8'h00;
  logic [7:0] OUT_PCL;
  logic [7:0] OUT_PCH;
  logic       BUSY;
  logic       PAGE_X;

  typedef struct {
    logic [15:0] pc;
    logic        busy;
    logic        page_x;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 CLK = ~CLK;

  misc_pc_sequencer dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .sig_INC (sig_INC),
    .sig_LDL (sig_LDL),
    .sig_LDH (sig_LDH),
    .sig_BR  (sig_BR),
    .IN_DB   (IN_DB),
    .OUT_PCL (OUT_PCL),
    .OUT_PCH (OUT_PCH),
    .BUSY    (BUSY),
    .PAGE_X  (PAGE_X)
  );

  task automatic compare(input exp_t e);
    tests_run++;
    if ({OUT_PCH, OUT_PCL} !== e.pc || BUSY !== e.busy || PAGE_X !== e.page_x) begin
      tests_failed++;
      $display("FAIL %s: got pc=%h busy=%b page_x=%b, expected pc=%h busy=%b page_x=%b",
               e.name, {OUT_PCH, OUT_PCL}, BUSY, PAGE_X, e.pc, e.busy, e.page_x);
    end
  endtask

  // Monitor: one expectation per clock, sampled just after the rising edge
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      compare(mon_e);
    end
  end

  task automatic cyc(input logic rst, input logic inc, input logic ldl, input logic ldh,
                     input logic br, input logic [7:0] db, input logic [15:0] pc,
                     input logic busy, input logic px, input string name);
    exp_t e;
    @(negedge CLK);
    RST_N   = rst;
    sig_INC = inc;
    sig_LDL = ldl;
    sig_LDH = ldh;
    sig_BR  = br;
    IN_DB   = db;
    e.pc     = pc;
    e.busy   = busy;
    e.page_x = px;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t now_e;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFC, 1'b0, 1'b0, "reset_hold");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFC, 1'b0, 1'b0, "release");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFD, 1'b0, 1'b0, "inc1");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFE, 1'b0, 1'b0, "inc2");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, 1'b0, 1'b0, "inc3");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, "inc_wrap");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 16'h0000, 1'b0, 1'b0, "hold");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 16'h1200, 1'b0, 1'b0, "ldh_12");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 16'h12FF, 1'b0, 1'b0, "ldl_ff");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h1300, 1'b0, 1'b0, "inc_carry");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 16'h1200, 1'b0, 1'b0, "ldh_12b");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h34, 16'h1234, 1'b0, 1'b0, "ldl_34");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h78, 16'h1278, 1'b0, 1'b0, "ldl_78");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h56, 16'h5678, 1'b0, 1'b0, "ldh_56");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAB, 16'hABAB, 1'b0, 1'b0, "ld_both");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 16'hABAF, 1'b0, 1'b0, "br_prio");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 16'hAB10, 1'b0, 1'b0, "ld_over_inc");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 16'hAB80, 1'b0, 1'b0, "ldl_80");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 16'hABFF, 1'b0, 1'b0, "br_nocross");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h10FF, 1'b0, 1'b0, "ldh_10");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 16'h10F0, 1'b0, 1'b0, "ldl_f0");
`ifdef MISC_PC_BRANCH_PENALTY_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1010, 1'b1, 1'b0, "br_fwd_c1");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 16'h1110, 1'b0, 1'b1, "br_fwd_fix");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 16'h1111, 1'b0, 1'b0, "inc_after_busy");
`else
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1110, 1'b0, 1'b1, "br_fwd");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 16'h1111, 1'b0, 1'b0, "inc_after_br");
`endif
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h1111, 1'b0, 1'b0, "hold_fwd");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h1011, 1'b0, 1'b0, "ldh_10b");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 16'h1005, 1'b0, 1'b0, "ldl_05");
`ifdef MISC_PC_BRANCH_PENALTY_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 16'h10F5, 1'b1, 1'b0, "br_bwd_c1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0FF5, 1'b0, 1'b1, "br_bwd_fix");
`else
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 16'h0FF5, 1'b0, 1'b1, "br_bwd");
`endif
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0FF5, 1'b0, 1'b0, "hold_bwd");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h10F5, 1'b0, 1'b0, "ldh_10c");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 16'h10F0, 1'b0, 1'b0, "ldl_f0b");
`ifdef MISC_PC_BRANCH_PENALTY_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1010, 1'b1, 1'b0, "br_then_rst");
`else
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1110, 1'b0, 1'b1, "br_then_rst");
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFC, 1'b0, 1'b0, "rst_in_fixup");
    #1;
    now_e.pc     = 16'hFFFC;
    now_e.busy   = 1'b0;
    now_e.page_x = 1'b0;
    now_e.name   = "rst_async";
    compare(now_e);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFC, 1'b0, 1'b0, "rst_release");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFC, 1'b0, 1'b0, "no_late_fix");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFD, 1'b0, 1'b0, "inc_post_rst");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFD, 1'b0, 1'b0, "final_hold");
    repeat (2) @(posedge CLK);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
